// File: rtl/frog_collision_ctrl.sv
// Game-state controller: collision and goal detection, lives/level/score tracking,
// and frog-reset / game-over signalling for the car lanes.
module frog_collision_ctrl #(
   parameter int NUM_CARS    = 4,
   parameter int CAR_ROW0    = 1,
   parameter int GOAL_ROW    = 0,
   parameter int START_LIVES = 3,
   parameter int MAX_LEVEL   = 15,
   parameter int HIT_HOLD    = 8
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_start,
   input  logic [5*NUM_CARS-1:0] i_car_x,
   input  logic [4:0]            i_frog_x,
   input  logic [3:0]            i_frog_y,
   output logic [3:0]            o_level,
   output logic [2:0]            o_lives,
   output logic [7:0]            o_score,
   output logic                  o_hit,
   output logic                  o_goal,
   output logic                  o_frog_reset,
   output logic                  o_game_over
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY,
      S_HIT,
      S_GOAL,
      S_OVER
   } state_t;

   localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
   localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [7:0] HOLD_LAST  = 8'(HIT_HOLD - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [3:0] level_nx;
   logic [2:0] lives_nx;
   logic [7:0] score_nx;
   logic       hit_nx, goal_nx;
   logic       collide, at_goal;

   always_comb begin
      collide = 1'b0;
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
         if (i_frog_y == 4'(CAR_ROW0 + k) && i_frog_x == i_car_x[5*k +: 5])
            collide = 1'b1;
      end
      at_goal = (i_frog_y == 4'(GOAL_ROW));
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         o_level      <= 4'd1;
         o_lives      <= LIVES_INIT;
         o_score      <= '0;
         o_hit        <= 1'b0;
         o_goal       <= 1'b0;
         o_frog_reset <= 1'b1;
         o_game_over  <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         o_level      <= level_nx;
         o_lives      <= lives_nx;
         o_score      <= score_nx;
         o_hit        <= hit_nx;
         o_goal       <= goal_nx;
         o_frog_reset <= (state_nx != S_PLAY);
         o_game_over  <= (state_nx == S_OVER);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (i_start) state_nx = S_PLAY;
         S_PLAY: begin
            if (collide && o_lives != '0)
               state_nx = (o_lives == 3'd1) ? S_OVER : S_HIT;
            else if (at_goal)
               state_nx = S_GOAL;
         end
         S_HIT:   if (cnt == HOLD_LAST) state_nx = S_PLAY;
         S_GOAL:  state_nx = S_PLAY;
         S_OVER:  if (i_start) state_nx = S_PLAY;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_nx   = cnt;
      level_nx = o_level;
      lives_nx = o_lives;
      score_nx = o_score;
      hit_nx   = 1'b0;
      goal_nx  = 1'b0;
      case (state)
         S_IDLE, S_OVER: begin
            if (i_start) begin
               lives_nx = LIVES_INIT;
               level_nx = 4'd1;
               score_nx = '0;
            end
         end
         S_PLAY: begin
            // Collision wins over goal when both match on a misconfigured row map.
            if (collide && o_lives != '0) begin
               lives_nx = o_lives - 3'd1;
               hit_nx   = 1'b1;
               cnt_nx   = '0;
            end else if (at_goal) begin
               goal_nx  = 1'b1;
               score_nx = (o_score == 8'hFF) ? o_score : o_score + 8'd1;
               level_nx = (o_level >= LEVEL_MAX) ? LEVEL_MAX : o_level + 4'd1;
            end
         end
         S_HIT:   cnt_nx = cnt + 8'd1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Self-checking bench for frog_collision_ctrl: directed scenarios followed by
// randomized play, all compared against a cycle-level behavioural game model.
module tb_frog_collision_ctrl;

   localparam int NUM_CARS    = 4;
   localparam int CAR_ROW0    = 1;
   localparam int GOAL_ROW    = 0;
   localparam int START_LIVES = 3;
   localparam int MAX_LEVEL   = 15;
   localparam int HIT_HOLD    = 8;

   logic                  i_Clk = 1'b0;
   logic                  i_Rst = 1'b0;
   logic                  i_start = 1'b0;
   logic [5*NUM_CARS-1:0] i_car_x;
   logic [4:0]            i_frog_x = 5'd10;
   logic [3:0]            i_frog_y = 4'd10;
   logic [3:0]            o_level;
   logic [2:0]            o_lives;
   logic [7:0]            o_score;
   logic                  o_hit, o_goal, o_frog_reset, o_game_over;

   int cx [NUM_CARS];
   int checks = 0;
   int failures = 0;
   int hit_count = 0;

   // Model of the game: "waiting" covers both before-first-start and game over.
   bit m_waiting, m_over, m_hit, m_goal;
   int m_lives, m_level, m_score, m_hold;

   frog_collision_ctrl #(
      .NUM_CARS(NUM_CARS), .CAR_ROW0(CAR_ROW0), .GOAL_ROW(GOAL_ROW),
      .START_LIVES(START_LIVES), .MAX_LEVEL(MAX_LEVEL), .HIT_HOLD(HIT_HOLD)
   ) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_start(i_start), .i_car_x(i_car_x),
      .i_frog_x(i_frog_x), .i_frog_y(i_frog_y), .o_level(o_level),
      .o_lives(o_lives), .o_score(o_score), .o_hit(o_hit), .o_goal(o_goal),
      .o_frog_reset(o_frog_reset), .o_game_over(o_game_over)
   );

   always #5 i_Clk = ~i_Clk;

   always_comb begin
      for (int k = 0; k < NUM_CARS; k++) i_car_x[5*k +: 5] = 5'(cx[k]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit frog_on_car();
      for (int k = 0; k < NUM_CARS; k++)
         if (int'(i_frog_y) == CAR_ROW0 + k && int'(i_frog_x) == cx[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge();
      m_hit  = 1'b0;
      m_goal = 1'b0;
      if (i_Rst) begin
         m_waiting = 1'b1; m_over = 1'b0; m_hold = 0;
         m_lives = START_LIVES; m_level = 1; m_score = 0;
      end else if (m_waiting) begin
         if (i_start) begin
            m_waiting = 1'b0; m_over = 1'b0; m_hold = 0;
            m_lives = START_LIVES; m_level = 1; m_score = 0;
         end
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (frog_on_car()) begin
         m_lives--;
         m_hit = 1'b1;
         if (m_lives == 0) begin
            m_waiting = 1'b1; m_over = 1'b1;
         end else begin
            m_hold = HIT_HOLD;
         end
      end else if (int'(i_frog_y) == GOAL_ROW) begin
         m_goal  = 1'b1;
         m_score = (m_score < 255) ? m_score + 1 : 255;
         m_level = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
         m_hold  = 1;
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge i_Clk);
      #1;
      if (o_hit === 1'b1) hit_count++;
      chk({tag, ".level"},      32'(o_level),      32'(m_level));
      chk({tag, ".lives"},      32'(o_lives),      32'(m_lives));
      chk({tag, ".score"},      32'(o_score),      32'(m_score));
      chk({tag, ".hit"},        32'(o_hit),        32'(m_hit));
      chk({tag, ".goal"},       32'(o_goal),       32'(m_goal));
      chk({tag, ".frog_reset"}, 32'(o_frog_reset), 32'(m_waiting || m_hold > 0));
      chk({tag, ".game_over"},  32'(o_game_over),  32'(m_over));
   endtask

   initial begin
      cx[0] = 12; cx[1] = 7; cx[2] = 3; cx[3] = 16;

      // Reset and start
      i_Rst = 1'b1; step("reset"); i_Rst = 1'b0;
      chk("reset.lives_const", 32'(o_lives), 32'd3);
      chk("reset.frog_reset_const", 32'(o_frog_reset), 32'd1);
      i_start = 1'b1; step("start"); i_start = 1'b0;
      chk("start.frog_reset_const", 32'(o_frog_reset), 32'd0);
      step("play_idle");

      // Collision held across the whole hit hold: one decrement per hit
      i_frog_x = 5'd5; i_frog_y = 4'd1; cx[0] = 5;
      hit_count = 0;
      for (int i = 0; i < 1 + HIT_HOLD; i++) step("hit1");
      chk("hit1.pulses", 32'(hit_count), 32'd1);
      chk("hit1.lives_const", 32'(o_lives), 32'd2);
      for (int i = 0; i < 2 * (1 + HIT_HOLD); i++) step("hit23");
      chk("over.game_over_const", 32'(o_game_over), 32'd1);
      chk("over.lives_const", 32'(o_lives), 32'd0);
      step("over_hold");
      i_frog_x = 5'd10; i_frog_y = 4'd10;
      i_start = 1'b1; step("restart"); i_start = 1'b0;
      chk("restart.lives_const", 32'(o_lives), 32'd3);

      // Goals: level saturates, score keeps counting
      i_frog_y = 4'(GOAL_ROW);
      step("goal1");
      chk("goal1.score_const", 32'(o_score), 32'd1);
      chk("goal1.level_const", 32'(o_level), 32'd2);
      for (int i = 0; i < 39; i++) step("goals");
      chk("goals.score_const", 32'(o_score), 32'd20);
      chk("goals.level_const", 32'(o_level), 32'd15);

      // Car 1 wrapping onto a frog at column 0
      i_frog_x = 5'd0; i_frog_y = 4'd2; cx[1] = 18;
      step("wrap18");
      cx[1] = 19; step("wrap19");
      cx[1] = 0;  step("wrap0");
      chk("wrap0.hit_const", 32'(o_hit), 32'd1);
      i_frog_x = 5'd19;
      for (int i = 0; i < HIT_HOLD + 4; i++) begin
         cx[1] = (i % 2 == 0) ? 0 : 1;
         step("wrap_after");
      end

      // Reset in the middle of a hit hold
      i_frog_x = 5'd5; i_frog_y = 4'd1; cx[0] = 5;
      for (int i = 0; i < 5; i++) step("midhit");
      i_Rst = 1'b1; step("midhit_rst"); i_Rst = 1'b0;
      chk("midhit_rst.hit_const", 32'(o_hit), 32'd0);
      i_frog_x = 5'd10; i_frog_y = 4'd10;
      step("post_rst_idle");

      // Randomized play
      for (int i = 0; i < 800; i++) begin
         i_Rst   = ($urandom_range(0, 99) == 0);
         i_start = ($urandom_range(0, 15) == 0);
         for (int k = 0; k < NUM_CARS; k++) cx[k] = $urandom_range(0, 19);
         i_frog_y = 4'($urandom_range(0, 6));
         if ($urandom_range(0, 2) == 0 && int'(i_frog_y) >= CAR_ROW0 &&
             int'(i_frog_y) < CAR_ROW0 + NUM_CARS)
            i_frog_x = 5'(cx[int'(i_frog_y) - CAR_ROW0]);
         else
            i_frog_x = 5'($urandom_range(0, 21));
         step("rand");
      end
      i_Rst = 1'b0; i_start = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
